// File: rtl/move_gate.sv
// Move-acceptance controller: turns click edges into one accept/reject pulse each.
// It also sequences the settle window, the win/draw evaluation and the turn rotation.
module move_gate #(
    parameter int CELLS      = 9,
    parameter int COORD_W    = 4,
    parameter int PLAYERS    = 2,
    parameter int SETTLE_CYC = 1,
    localparam int PLAYER_W  = (PLAYERS > 2) ? $clog2(PLAYERS) : 1,
    localparam int COUNT_W   = $clog2(CELLS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                new_game,
    input  logic                click_n,
    input  logic [COORD_W-1:0]  coord,
    input  logic [PLAYER_W-1:0] player_id,
    input  logic [CELLS-1:0]    occupied,
    input  logic                win,
    output logic                move_accept,
    output logic                move_reject,
    output logic [2:0]          reject_reason,
    output logic [COORD_W-1:0]  move_coord,
    output logic [PLAYER_W-1:0] move_player,
    output logic [PLAYER_W-1:0] turn,
    output logic [COUNT_W-1:0]  move_count,
    output logic                game_over,
    output logic                draw,
    output logic [PLAYER_W-1:0] winner
);

    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [COORD_W:0] CELLS_X = (COORD_W + 1)'(CELLS);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_SETTLE,
        ST_OVER
    } state_t;

    typedef enum logic [2:0] {
        RSN_NONE       = 3'd0,
        RSN_OFF_BOARD  = 3'd1,
        RSN_OCCUPIED   = 3'd2,
        RSN_WRONG_TURN = 3'd3,
        RSN_BUSY       = 3'd4
    } reason_t;

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  click_q;
    reason_t               reason_q, reason_d;
    logic                  accept_d, reject_d;
    logic [COORD_W-1:0]    coord_d;
    logic [PLAYER_W-1:0]   player_d, turn_d, winner_d;
    logic [COUNT_W-1:0]    count_d;
    logic                  draw_d;

    logic                  request;
    logic                  off_board;
    logic                  cell_taken;
    logic                  board_full;

    assign request    = click_q & ~click_n;
    assign off_board  = ({1'b0, coord} >= CELLS_X);
    assign board_full = &occupied;

    // Compare against each legal index so an off-board coord never forms an out-of-range select.
    always_comb begin
        cell_taken = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (coord == COORD_W'(i)) cell_taken = occupied[i];
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        turn_d   = turn;
        count_d  = move_count;
        coord_d  = move_coord;
        player_d = move_player;
        draw_d   = draw;
        winner_d = winner;
        accept_d = 1'b0;
        reject_d = 1'b0;
        reason_d = RSN_NONE;

        if (new_game) begin
            state_d  = ST_PLAY;
            settle_d = '0;
            turn_d   = '0;
            count_d  = '0;
            draw_d   = 1'b0;
            winner_d = '0;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (request) begin
                        if (off_board) begin
                            reject_d = 1'b1;
                            reason_d = RSN_OFF_BOARD;
                        end else if (cell_taken) begin
                            reject_d = 1'b1;
                            reason_d = RSN_OCCUPIED;
                        end else if (player_id != turn) begin
                            reject_d = 1'b1;
                            reason_d = RSN_WRONG_TURN;
                        end else begin
                            accept_d = 1'b1;
                            coord_d  = coord;
                            player_d = player_id;
                            count_d  = move_count + COUNT_W'(1);
                            settle_d = SETTLE_W'(SETTLE_CYC);
                            state_d  = ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (request) begin
                        reject_d = 1'b1;
                        reason_d = RSN_BUSY;
                    end
                    // The board registers have settled once the count is exhausted.
                    if (settle_q != '0) begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end else if (win) begin
                        state_d  = ST_OVER;
                        winner_d = move_player;
                        draw_d   = 1'b0;
                    end else if (board_full || (move_count == COUNT_W'(CELLS))) begin
                        state_d = ST_OVER;
                        draw_d  = 1'b1;
                    end else begin
                        turn_d  = (turn == PLAYER_W'(PLAYERS - 1)) ? '0 : turn + PLAYER_W'(1);
                        state_d = ST_PLAY;
                    end
                end

                ST_OVER: begin
                    if (request) begin
                        reject_d = 1'b1;
                        reason_d = RSN_BUSY;
                    end
                end

                default: state_d = ST_PLAY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLAY;
            settle_q    <= '0;
            click_q     <= 1'b1;
            reason_q    <= RSN_NONE;
            move_accept <= 1'b0;
            move_reject <= 1'b0;
            move_coord  <= '0;
            move_player <= '0;
            turn        <= '0;
            move_count  <= '0;
            draw        <= 1'b0;
            winner      <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            click_q     <= click_n;
            reason_q    <= reason_d;
            move_accept <= accept_d;
            move_reject <= reject_d;
            move_coord  <= coord_d;
            move_player <= player_d;
            turn        <= turn_d;
            move_count  <= count_d;
            draw        <= draw_d;
            winner      <= winner_d;
        end
    end

    assign reject_reason = reason_q;
    assign game_over     = (state_q == ST_OVER);

endmodule

// File: tb/tb_move_gate.sv
// Bench for move_gate: default instance checked against an event-level model every cycle,
// plus a 3-player / 3-cycle-settle instance exercised with hand-written sequences.
module tb_move_gate;

    localparam int CELLS = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance A: default parameters
    logic       new_game_a = 1'b0, click_n_a = 1'b1, win_a = 1'b0;
    logic [3:0] coord_a = '0;
    logic [0:0] pid_a = '0;
    logic [8:0] occ_a = '0;
    logic       accept_a, reject_a, over_a, draw_a;
    logic [2:0] reason_a;
    logic [3:0] mcoord_a, count_a;
    logic [0:0] mplayer_a, turn_a, winner_a;

    // Instance B: PLAYERS=3, SETTLE_CYC=3
    logic       new_game_b = 1'b0, click_n_b = 1'b1, win_b = 1'b0;
    logic [3:0] coord_b = '0;
    logic [1:0] pid_b = '0;
    logic [8:0] occ_b = '0;
    logic       accept_b, reject_b, over_b, draw_b;
    logic [2:0] reason_b;
    logic [3:0] mcoord_b, count_b;
    logic [1:0] mplayer_b, turn_b, winner_b;

    move_gate dut_a (
        .clk(clk), .rst_n(rst_n), .new_game(new_game_a), .click_n(click_n_a),
        .coord(coord_a), .player_id(pid_a), .occupied(occ_a), .win(win_a),
        .move_accept(accept_a), .move_reject(reject_a), .reject_reason(reason_a),
        .move_coord(mcoord_a), .move_player(mplayer_a), .turn(turn_a),
        .move_count(count_a), .game_over(over_a), .draw(draw_a), .winner(winner_a)
    );

    move_gate #(.PLAYERS(3), .SETTLE_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .new_game(new_game_b), .click_n(click_n_b),
        .coord(coord_b), .player_id(pid_b), .occupied(occ_b), .win(win_b),
        .move_accept(accept_b), .move_reject(reject_b), .reject_reason(reason_b),
        .move_coord(mcoord_b), .move_player(mplayer_b), .turn(turn_b),
        .move_count(count_b), .game_over(over_b), .draw(draw_b), .winner(winner_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for instance A, tracked as events: a move settles at an absolute edge index.
    int m_cyc, m_eval_at, m_winner, m_turn, m_count, m_coord, m_player, e_reason;
    bit m_click_q, m_over, m_draw, e_acc, e_rej;

    function automatic void model_reset();
        m_cyc = 0; m_eval_at = -1; m_winner = 0; m_turn = 0; m_count = 0;
        m_coord = 0; m_player = 0; m_click_q = 1'b1; m_over = 1'b0; m_draw = 1'b0;
        e_acc = 1'b0; e_rej = 1'b0; e_reason = 0;
    endfunction

    function automatic void model_step();
        bit req;
        req = m_click_q && !click_n_a;
        e_acc = 1'b0; e_rej = 1'b0; e_reason = 0;
        if (new_game_a) begin
            m_over = 1'b0; m_draw = 1'b0; m_winner = 0; m_turn = 0; m_count = 0; m_eval_at = -1;
        end else if (m_over) begin
            if (req) begin e_rej = 1'b1; e_reason = 4; end
        end else if (m_eval_at >= 0) begin
            if (req) begin e_rej = 1'b1; e_reason = 4; end
            if (m_cyc == m_eval_at) begin
                m_eval_at = -1;
                if (win_a) begin
                    m_over = 1'b1; m_winner = m_player;
                end else if (occ_a == 9'h1ff || m_count == CELLS) begin
                    m_over = 1'b1; m_draw = 1'b1;
                end else begin
                    m_turn = (m_turn + 1) % 2;
                end
            end
        end else if (req) begin
            if (int'(coord_a) >= CELLS) begin
                e_rej = 1'b1; e_reason = 1;
            end else if (((occ_a >> coord_a) & 9'd1) != 9'd0) begin
                e_rej = 1'b1; e_reason = 2;
            end else if (int'(pid_a) != m_turn) begin
                e_rej = 1'b1; e_reason = 3;
            end else begin
                e_acc = 1'b1;
                m_coord = int'(coord_a);
                m_player = int'(pid_a);
                m_count++;
                m_eval_at = m_cyc + 1 + 1;
            end
        end
        m_click_q = click_n_a;
        m_cyc++;
    endfunction

    task automatic compare_model();
        check("a_accept", 32'(accept_a), 32'(e_acc));
        check("a_reject", 32'(reject_a), 32'(e_rej));
        check("a_reason", 32'(reason_a), 32'(e_reason));
        check("a_turn", 32'(turn_a), 32'(m_turn));
        check("a_count", 32'(count_a), 32'(m_count));
        check("a_over", 32'(over_a), 32'(m_over));
        check("a_draw", 32'(draw_a), 32'(m_draw));
        check("a_winner", 32'(winner_a), 32'(m_winner));
        check("a_mcoord", 32'(mcoord_a), 32'(m_coord));
        check("a_mplayer", 32'(mplayer_a), 32'(m_player));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [3:0] coord;
        logic [0:0] pid;
        logic [8:0] occ;
        logic       acc;
        logic [2:0] reason;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pulses;

        vecs[0] = '{coord: 4'd4,  pid: 1'b0, occ: 9'h000, acc: 1'b1, reason: 3'd0};
        vecs[1] = '{coord: 4'd15, pid: 1'b0, occ: 9'h000, acc: 1'b0, reason: 3'd1};
        vecs[2] = '{coord: 4'd9,  pid: 1'b0, occ: 9'h000, acc: 1'b0, reason: 3'd1};
        vecs[3] = '{coord: 4'd4,  pid: 1'b0, occ: 9'h010, acc: 1'b0, reason: 3'd2};
        vecs[4] = '{coord: 4'd4,  pid: 1'b1, occ: 9'h000, acc: 1'b0, reason: 3'd3};
        vecs[5] = '{coord: 4'd15, pid: 1'b1, occ: 9'h1ff, acc: 1'b0, reason: 3'd1};
        vecs[6] = '{coord: 4'd8,  pid: 1'b1, occ: 9'h100, acc: 1'b0, reason: 3'd2};
        vecs[7] = '{coord: 4'd0,  pid: 1'b0, occ: 9'h1fe, acc: 1'b1, reason: 3'd0};

        // Reset state
        model_reset();
        #12;
        check("rst_a_accept", 32'(accept_a), 32'd0);
        check("rst_a_reject", 32'(reject_a), 32'd0);
        check("rst_a_reason", 32'(reason_a), 32'd0);
        check("rst_a_turn", 32'(turn_a), 32'd0);
        check("rst_a_count", 32'(count_a), 32'd0);
        check("rst_a_over", 32'(over_a), 32'd0);
        check("rst_b_turn", 32'(turn_b), 32'd0);
        check("rst_b_count", 32'(count_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First move with defaults; click held low through the settle window
        click_n_a = 1'b0; coord_a = 4'd4; pid_a = 1'b0; occ_a = '0;
        tick();
        check("first_accept", 32'(accept_a), 32'd1);
        check("first_mcoord", 32'(mcoord_a), 32'd4);
        tick();
        check("first_turn_mid", 32'(turn_a), 32'd0);
        check("first_no_repeat", 32'(accept_a | reject_a), 32'd0);
        tick();
        check("first_turn_after", 32'(turn_a), 32'd1);
        check("first_count", 32'(count_a), 32'd1);
        click_n_a = 1'b1;
        tick();

        // Single-request vectors, each from a fresh game
        for (int v = 0; v < 8; v++) begin
            new_game_a = 1'b1; click_n_a = 1'b1;
            tick();
            new_game_a = 1'b0;
            coord_a = vecs[v].coord; pid_a = vecs[v].pid; occ_a = vecs[v].occ;
            click_n_a = 1'b0;
            tick();
            check($sformatf("vec%0d_accept", v), 32'(accept_a), 32'(vecs[v].acc));
            check($sformatf("vec%0d_reject", v), 32'(reject_a), 32'(!vecs[v].acc));
            check($sformatf("vec%0d_reason", v), 32'(reason_a), 32'(vecs[v].reason));
            click_n_a = 1'b1;
            tick();
            check($sformatf("vec%0d_turn", v), 32'(turn_a), 32'd0);
            check($sformatf("vec%0d_count", v), 32'(count_a), 32'(vecs[v].acc));
            check($sformatf("vec%0d_pulse_off", v), 32'(reject_a | accept_a), 32'd0);
        end

        // Win at the end of the settle window, then locked, then new_game
        new_game_a = 1'b1; occ_a = '0;
        tick();
        new_game_a = 1'b0;
        coord_a = 4'd2; pid_a = 1'b0; win_a = 1'b1; click_n_a = 1'b0;
        tick();
        click_n_a = 1'b1;
        tick();
        tick();
        check("win_over", 32'(over_a), 32'd1);
        check("win_winner", 32'(winner_a), 32'd0);
        check("win_draw", 32'(draw_a), 32'd0);
        win_a = 1'b0; click_n_a = 1'b0; coord_a = 4'd5;
        tick();
        check("over_reason", 32'(reason_a), 32'd4);
        click_n_a = 1'b1; new_game_a = 1'b1;
        tick();
        new_game_a = 1'b0;
        check("ng_over", 32'(over_a), 32'd0);
        check("ng_turn", 32'(turn_a), 32'd0);
        check("ng_count", 32'(count_a), 32'd0);

        // Nine accepted moves with no win end in a draw
        for (int m = 0; m < 9; m++) begin
            coord_a = 4'(m); pid_a = 1'(m % 2); click_n_a = 1'b0;
            tick();
            check($sformatf("draw_mv%0d_accept", m), 32'(accept_a), 32'd1);
            click_n_a = 1'b1;
            tick();
            tick();
        end
        check("draw_over", 32'(over_a), 32'd1);
        check("draw_draw", 32'(draw_a), 32'd1);
        check("draw_count", 32'(count_a), 32'd9);

        // Instance B: click during a 3-cycle settle window
        click_n_b = 1'b0; coord_b = 4'd2; pid_b = 2'd0;
        tick();
        check("b_mv0_accept", 32'(accept_b), 32'd1);
        click_n_b = 1'b1;
        tick();
        click_n_b = 1'b0; coord_b = 4'd3; pid_b = 2'd1;
        tick();
        check("b_busy_reject", 32'(reject_b), 32'd1);
        check("b_busy_reason", 32'(reason_b), 32'd4);
        click_n_b = 1'b1;
        tick();
        check("b_turn_still0", 32'(turn_b), 32'd0);
        tick();
        check("b_turn_1", 32'(turn_b), 32'd1);
        check("b_count_1", 32'(count_b), 32'd1);

        // Player 1 then player 2, the latter with a long click
        click_n_b = 1'b0; coord_b = 4'd3; pid_b = 2'd1;
        tick();
        check("b_mv1_accept", 32'(accept_b), 32'd1);
        click_n_b = 1'b1;
        repeat (4) tick();
        check("b_turn_2", 32'(turn_b), 32'd2);
        click_n_b = 1'b0; coord_b = 4'd5; pid_b = 2'd2;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            pulses += int'(accept_b) + int'(reject_b);
        end
        check("b_long_click_pulses", 32'(pulses), 32'd1);
        click_n_b = 1'b1;
        tick();
        check("b_turn_wrap", 32'(turn_b), 32'd0);
        check("b_count_3", 32'(count_b), 32'd3);

        // Reset in the middle of a settle window
        click_n_b = 1'b0; coord_b = 4'd7; pid_b = 2'd0;
        tick();
        check("b_mv3_accept", 32'(accept_b), 32'd1);
        click_n_b = 1'b1;
        tick();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("b_rst_count", 32'(count_b), 32'd0);
        check("b_rst_turn", 32'(turn_b), 32'd0);
        check("b_rst_mcoord", 32'(mcoord_b), 32'd0);
        check("b_rst_accept", 32'(accept_b), 32'd0);
        check("b_rst_over", 32'(over_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        click_n_b = 1'b0; coord_b = 4'd7; pid_b = 2'd0;
        tick();
        check("b_after_rst_accept", 32'(accept_b), 32'd1);
        check("b_after_rst_count", 32'(count_b), 32'd1);
        click_n_b = 1'b1;
        tick();

        // Randomized traffic on instance A against the model
        for (int i = 0; i < 2000; i++) begin
            new_game_a = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) click_n_a = ~click_n_a;
            coord_a = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            pid_a = ($urandom_range(0, 3) == 0) ? 1'($urandom) : 1'(m_turn);
            occ_a = 9'($urandom) & 9'($urandom) & 9'($urandom);
            if ($urandom_range(0, 19) == 0) occ_a = 9'h1ff;
            win_a = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
